// File: rtl/m72_loader_pkg.sv
// Shared types and default address map for the m72 ROM download loader.
package m72_loader_pkg;

  typedef enum logic [2:0] {
    REG_CPU  = 3'd0,
    REG_SND  = 3'd1,
    REG_SPR  = 3'd2,
    REG_TILE = 3'd3,
    REG_SAMP = 3'd4
  } region_t;

  localparam logic [24:0] DEF_SND_BASE  = 25'h0100000;
  localparam logic [24:0] DEF_SPR_BASE  = 25'h0110000;
  localparam logic [24:0] DEF_TILE_BASE = 25'h0310000;
  localparam logic [24:0] DEF_SAMP_BASE = 25'h0510000;

  typedef struct packed {
    region_t     region;
    logic [23:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } word_t;

  // The region is the highest base not above the byte address; the offset is in words.
  function automatic word_t make_word(input logic [24:0] byte_addr,
                                      input logic [15:0] data,
                                      input logic [1:0]  be,
                                      input logic [24:0] snd_base,
                                      input logic [24:0] spr_base,
                                      input logic [24:0] tile_base,
                                      input logic [24:0] samp_base);
    word_t       w;
    logic [24:0] base;
    w.data = data;
    w.be   = be;
    if (byte_addr >= samp_base) begin
      w.region = REG_SAMP;
      base     = samp_base;
    end else if (byte_addr >= tile_base) begin
      w.region = REG_TILE;
      base     = tile_base;
    end else if (byte_addr >= spr_base) begin
      w.region = REG_SPR;
      base     = spr_base;
    end else if (byte_addr >= snd_base) begin
      w.region = REG_SND;
      base     = snd_base;
    end else begin
      w.region = REG_CPU;
      base     = '0;
    end
    w.addr = 24'((byte_addr - base) >> 1);
    return w;
  endfunction

endpackage

// File: rtl/m72_loader_fifo.sv
// Small synchronous FIFO of packed entries; DEPTH must be a power of two so the
// pointers wrap naturally.
module m72_loader_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0],
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/m72_rom_loader.sv
// Packs the byte-wide ioctl ROM download into 16-bit words, decodes the target
// region and delivers words to a req/ack write port through a small FIFO.
module m72_rom_loader
  import m72_loader_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX  = 8'd0,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] SND_BASE   = DEF_SND_BASE,
  parameter logic [24:0] SPR_BASE   = DEF_SPR_BASE,
  parameter logic [24:0] TILE_BASE  = DEF_TILE_BASE,
  parameter logic [24:0] SAMP_BASE  = DEF_SAMP_BASE
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [2:0]  mem_region,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_data,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  output logic        rom_ready,
  output logic        overflow
);

  localparam int            CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] WAIT_LEVEL = CW'(FIFO_DEPTH - 1);

  logic          pend_valid, hold_valid, dl_prev, armed;
  logic [7:0]    pend_data, hold_data;
  logic [23:0]   pend_waddr, hold_waddr;
  logic          accept, pend_match, push, push_fire, pop, drop;
  logic          pend_set, pend_clr, hold_set, hold_clr, hold_next;
  logic [24:0]   push_baddr;
  logic [15:0]   push_wdata;
  logic [1:0]    push_be;
  word_t         push_word, head;
  logic [CW-1:0] count, count_next;
  logic          full, empty;

  assign accept     = ioctl_download & ioctl_wr & (ioctl_index == ROM_INDEX);
  assign pend_match = (pend_waddr == ioctl_addr[24:1]);

  // A lone pending byte is the default push payload; other cases override it.
  always_comb begin
    push       = 1'b0;
    push_baddr = {pend_waddr, 1'b0};
    push_wdata = {8'h00, pend_data};
    push_be    = 2'b01;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    hold_set   = 1'b0;
    hold_clr   = 1'b0;
    drop       = 1'b0;
    if (hold_valid) begin
      push       = 1'b1;
      push_baddr = {hold_waddr, 1'b1};
      push_wdata = {hold_data, 8'h00};
      push_be    = 2'b10;
      hold_clr   = ~full;
      drop       = accept;
    end else if (!ioctl_download && pend_valid) begin
      push     = 1'b1;
      pend_clr = ~full;
    end else if (accept) begin
      if (pend_valid && !(ioctl_addr[0] && pend_match)) begin
        push = 1'b1;
        drop = full;
        if (!full) begin
          pend_set = ~ioctl_addr[0];
          pend_clr = ioctl_addr[0];
          hold_set = ioctl_addr[0];
        end
      end else if (pend_valid) begin
        push       = 1'b1;
        push_wdata = {ioctl_dout, pend_data};
        push_be    = 2'b11;
        pend_clr   = ~full;
        drop       = full;
      end else if (ioctl_addr[0]) begin
        push       = 1'b1;
        push_baddr = ioctl_addr;
        push_wdata = {ioctl_dout, 8'h00};
        push_be    = 2'b10;
        drop       = full;
      end else begin
        pend_set = 1'b1;
      end
    end
  end

  assign push_fire  = push & ~full;
  assign pop        = ~empty & mem_ack;
  assign count_next = count + CW'(push_fire) - CW'(pop);
  assign hold_next  = hold_set | (hold_valid & ~hold_clr);
  assign push_word  = make_word(push_baddr, push_wdata, push_be,
                                SND_BASE, SPR_BASE, TILE_BASE, SAMP_BASE);

  m72_loader_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(word_t)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_fire),
    .push_data (push_word),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Head storage is not reset, so the port is forced to zero while idle.
  assign mem_req    = ~empty;
  assign mem_region = mem_req ? head.region : REG_CPU;
  assign mem_addr   = mem_req ? head.addr   : 24'h0;
  assign mem_data   = mem_req ? head.data   : 16'h0;
  assign mem_be     = mem_req ? head.be     : 2'b00;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_waddr <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_waddr <= '0;
      dl_prev    <= 1'b0;
      armed      <= 1'b0;
      ioctl_wait <= 1'b0;
      rom_ready  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dl_prev <= ioctl_download;
      if (pend_set) begin
        pend_valid <= 1'b1;
        pend_data  <= ioctl_dout;
        pend_waddr <= ioctl_addr[24:1];
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
      if (hold_set) begin
        hold_valid <= 1'b1;
        hold_data  <= ioctl_dout;
        hold_waddr <= ioctl_addr[24:1];
      end else if (hold_clr) begin
        hold_valid <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
      ioctl_wait <= (count_next >= WAIT_LEVEL) | hold_next;
      // armed keeps rom_ready low until a matching download has actually run.
      if (ioctl_download && !dl_prev && ioctl_index == ROM_INDEX) begin
        rom_ready <= 1'b0;
        armed     <= 1'b1;
      end else if (armed && !ioctl_download && !pend_valid && empty && !hold_valid) begin
        rom_ready <= 1'b1;
        armed     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m72_rom_loader.sv
// Self-checking bench for m72_rom_loader: directed scenarios with literal
// expectations plus a randomized byte stream checked against a packing model.
module tb_m72_rom_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic        mem_req;
  logic [2:0]  mem_region;
  logic [23:0] mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  mem_be;
  logic        mem_ack;
  logic        rom_ready;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;

  logic [44:0] got_q[$];
  logic [44:0] exp_q[$];

  logic        m_pend;
  logic [24:0] m_addr;
  logic [7:0]  m_data;

  m72_rom_loader dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_region     (mem_region),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_be         (mem_be),
    .mem_ack        (mem_ack),
    .rom_ready      (rom_ready),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  // Every accepted write is recorded mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (mem_req && mem_ack) got_q.push_back({mem_region, mem_addr, mem_data, mem_be});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_download(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    step();
  endtask

  task automatic end_download();
    ioctl_download = 1'b0;
    step();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int k = 0;
    while (ioctl_wait && k < 200) begin
      step();
      k++;
    end
    if (ioctl_wait) begin
      miscompares++;
      $display("[TB] FAIL wait_timeout ioctl_wait=%0b required 0", ioctl_wait);
    end
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (!rom_ready && k < 200) begin
      step();
      k++;
    end
  endtask

  // Reference model: region and word offset straight from the address map.
  function automatic logic [44:0] model_word(input logic [24:0] a, input logic [15:0] d,
                                             input logic [1:0] be);
    logic [2:0]  r;
    logic [24:0] base;
    if (a >= 25'h0510000)      begin r = 3'd4; base = 25'h0510000; end
    else if (a >= 25'h0310000) begin r = 3'd3; base = 25'h0310000; end
    else if (a >= 25'h0110000) begin r = 3'd2; base = 25'h0110000; end
    else if (a >= 25'h0100000) begin r = 3'd1; base = 25'h0100000; end
    else                       begin r = 3'd0; base = 25'h0;       end
    return {r, 24'((a - base) / 2), d, be};
  endfunction

  task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
    if (a[0] == 1'b0) begin
      if (m_pend) exp_q.push_back(model_word(m_addr, {8'h00, m_data}, 2'b01));
      m_pend = 1'b1;
      m_addr = a;
      m_data = d;
    end else if (m_pend && (m_addr / 2) == (a / 2)) begin
      exp_q.push_back(model_word(m_addr, {d, m_data}, 2'b11));
      m_pend = 1'b0;
    end else begin
      if (m_pend) exp_q.push_back(model_word(m_addr, {8'h00, m_data}, 2'b01));
      m_pend = 1'b0;
      exp_q.push_back(model_word(a, {d, 8'h00}, 2'b10));
    end
  endtask

  task automatic model_end();
    if (m_pend) exp_q.push_back(model_word(m_addr, {8'h00, m_data}, 2'b01));
    m_pend = 1'b0;
  endtask

  task automatic test_reset();
    vectors += 4;
    if (ioctl_wait !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_wait got %0b required 0", ioctl_wait);
    end
    if ({mem_req, mem_region, mem_addr, mem_data, mem_be} !== 46'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_mem got %h required 0", {mem_req, mem_region, mem_addr, mem_data, mem_be});
    end
    if (rom_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_rom_ready got %0b required 0", rom_ready);
    end
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_overflow got %0b required 0", overflow);
    end
  endtask

  task automatic test_basic_word();
    got_q.delete(); exp_q.delete();
    mem_ack = 1'b1;
    start_download(8'd0);
    send_byte(25'h0, 8'h11);
    send_byte(25'h1, 8'h22);
    end_download();
    drain();
    exp_q.push_back({3'd0, 24'h0, 16'h2211, 2'b11});
    vectors += 2;
    if (rom_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_rom_ready got %0b required 1", rom_ready);
    end
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL basic_count got %0d words required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL basic_word%0d got %h required %h", i, (i < got_q.size()) ? got_q[i] : 45'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_regions();
    logic [24:0] addrs[6] = '{25'h00FFFFE, 25'h0100000, 25'h0110000, 25'h0310002, 25'h0510004, 25'h1FFFFFE};
    logic [2:0]  regs[6]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic [23:0] offs[6]  = '{24'h07FFFF, 24'h0, 24'h0, 24'h1, 24'h2, 24'hD77FFF};
    logic [7:0]  lo, hi;
    got_q.delete(); exp_q.delete();
    mem_ack = 1'b1;
    start_download(8'd0);
    for (int i = 0; i < 6; i++) begin
      lo = (i == 2) ? 8'hAA : 8'($urandom);
      hi = (i == 2) ? 8'hBB : 8'($urandom);
      send_byte(addrs[i], lo);
      send_byte(addrs[i] + 25'd1, hi);
      exp_q.push_back({regs[i], offs[i], hi, lo, 2'b11});
    end
    end_download();
    drain();
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL regions_count got %0d words required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL regions_word%0d got %h required %h", i, (i < got_q.size()) ? got_q[i] : 45'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int rose_at = -1;
    int early_writes = -1;
    got_q.delete(); exp_q.delete();
    m_pend  = 1'b0;
    mem_ack = 1'b0;
    start_download(8'd0);
    for (int i = 0; i < 10; i++) begin
      if (ioctl_wait && rose_at < 0) begin
        rose_at      = exp_q.size();
        early_writes = got_q.size();
        mem_ack      = 1'b1;
      end
      send_byte(25'h0310100 + 25'(i), 8'($urandom));
      model_byte(25'h0310100 + 25'(i), ioctl_dout);
    end
    end_download();
    model_end();
    mem_ack = 1'b1;
    drain();
    vectors += 4;
    if (rose_at != 3) begin
      miscompares++;
      $display("[TB] FAIL bp_wait_level got wait at %0d words required 3", rose_at);
    end
    if (early_writes != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_no_ack_writes got %0d required 0", early_writes);
    end
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_overflow got %0b required 0", overflow);
    end
    if (got_q.size() != 5) begin
      miscompares++;
      $display("[TB] FAIL bp_count got %0d words required 5", got_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL bp_word%0d got %h required %h", i, (i < got_q.size()) ? got_q[i] : 45'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_lone_even();
    got_q.delete(); exp_q.delete();
    mem_ack = 1'b1;
    start_download(8'd0);
    send_byte(25'h20, 8'h5A);
    end_download();
    drain();
    exp_q.push_back({3'd0, 24'h10, 16'h005A, 2'b01});
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL lone_count got %0d words required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL lone_word%0d got %h required %h", i, (i < got_q.size()) ? got_q[i] : 45'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_noncontig();
    logic [7:0] a = 8'($urandom);
    logic [7:0] b = 8'($urandom);
    logic       w_before, w_pulse, w_after;
    got_q.delete(); exp_q.delete();
    mem_ack = 1'b1;
    start_download(8'd0);
    send_byte(25'h4, a);
    w_before = ioctl_wait;
    send_byte(25'h7, b);
    w_pulse = ioctl_wait;
    step();
    w_after = ioctl_wait;
    end_download();
    drain();
    exp_q.push_back({3'd0, 24'h2, 8'h00, a, 2'b01});
    exp_q.push_back({3'd0, 24'h3, b, 8'h00, 2'b10});
    vectors += 2;
    if ({w_before, w_pulse, w_after} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL nc_wait_pulse got %b required 010", {w_before, w_pulse, w_after});
    end
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL nc_count got %0d words required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL nc_word%0d got %h required %h", i, (i < got_q.size()) ? got_q[i] : 45'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_other_index();
    logic ready_mid;
    got_q.delete();
    mem_ack = 1'b1;
    start_download(8'h05);
    for (int i = 0; i < 4; i++) send_byte(25'h80 + 25'(i), 8'($urandom));
    ready_mid = rom_ready;
    end_download();
    repeat (5) step();
    vectors += 3;
    if (ready_mid !== 1'b1 || rom_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL other_rom_ready got %0b/%0b required 1/1", ready_mid, rom_ready);
    end
    if (got_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL other_writes got %0d required 0", got_q.size());
    end
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL other_overflow got %0b required 0", overflow);
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] d[4];
    logic       ready_start;
    got_q.delete(); exp_q.delete();
    mem_ack = 1'b0;
    start_download(8'd0);
    for (int i = 0; i < 4; i++) begin
      d[i] = 8'($urandom);
      send_byte(25'h40 + 25'(i), d[i]);
    end
    vectors += 3;
    if ({mem_req, mem_region, mem_addr, mem_data, mem_be} !== {1'b1, 3'd0, 24'h20, d[1], d[0], 2'b11}) begin
      miscompares++;
      $display("[TB] FAIL rst_head got %h required %h", {mem_req, mem_region, mem_addr, mem_data, mem_be},
               {1'b1, 3'd0, 24'h20, d[1], d[0], 2'b11});
    end
    #2 reset_n = 1'b0;
    #1;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_async_req got %0b required 0", mem_req);
    end
    if ({mem_region, mem_addr, mem_data, mem_be} !== 45'h0) begin
      miscompares++;
      $display("[TB] FAIL rst_async_bus got %h required 0", {mem_region, mem_addr, mem_data, mem_be});
    end
    ioctl_download = 1'b0;
    mem_ack        = 1'b1;
    step(); step();
    reset_n = 1'b1;
    repeat (5) step();
    vectors += 2;
    if (got_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL rst_stale_writes got %0d required 0", got_q.size());
    end
    if (rom_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_rom_ready got %0b required 0", rom_ready);
    end
    start_download(8'd0);
    ready_start = rom_ready;
    send_byte(25'h8, 8'h33);
    send_byte(25'h9, 8'h44);
    end_download();
    drain();
    exp_q.push_back({3'd0, 24'h4, 16'h4433, 2'b11});
    vectors += 2;
    if ({ready_start, rom_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL rst_next_ready got %b required 01", {ready_start, rom_ready});
    end
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL rst_next_count got %0d words required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL rst_next_word%0d got %h required %h", i, (i < got_q.size()) ? got_q[i] : 45'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [24:0] bases[6] = '{25'h0, 25'h0100000, 25'h0110000, 25'h0310000, 25'h0510000, 25'h1FFFFC0};
    logic [24:0] a = 25'h0;
    logic [7:0]  d;
    got_q.delete(); exp_q.delete();
    m_pend = 1'b0;
    start_download(8'd0);
    for (int c = 0; c < 600; c++) begin
      mem_ack = 1'($urandom_range(0, 1));
      if (!ioctl_wait && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 4) == 0) a = bases[$urandom_range(0, 5)] + 25'($urandom_range(0, 63));
        else                           a = a + 25'd1;
        d          = 8'($urandom);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        model_byte(a, d);
      end else begin
        ioctl_wr = 1'b0;
      end
      step();
    end
    ioctl_wr = 1'b0;
    end_download();
    model_end();
    mem_ack = 1'b1;
    drain();
    vectors += 3;
    if (rom_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rand_rom_ready got %0b required 1", rom_ready);
    end
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rand_overflow got %0b required 0", overflow);
    end
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL rand_count got %0d words required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL rand_word%0d got %h required %h", i, (i < got_q.size()) ? got_q[i] : 45'h0, exp_q[i]);
      end
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    mem_ack        = 1'b0;
    m_pend         = 1'b0;
    m_addr         = '0;
    m_data         = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    test_reset();
    test_basic_word();
    test_regions();
    test_backpressure();
    test_lone_even();
    test_noncontig();
    test_other_index();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/m72_rom_loader.md
Name: m72_rom_loader

Overview:
Upstream of the m72 core's ROM storage. Consumes the byte-wide ioctl download stream and packs bytes into 16-bit words. Decodes each word's target ROM region from its address and delivers it over a req/ack memory write port. Applies ioctl_wait back-pressure from a small word FIFO so slow SDRAM/BRAM writers never lose data, and flags completion.

Parameters:
ROM_INDEX, 8'd0, ioctl_index value accepted as ROM data; other indices ignored
FIFO_DEPTH, 4, word FIFO entries (power of two, >=2)
SND_BASE, 25'h100000, first byte of sound-CPU ROM (CPU ROM is 0..SND_BASE-1)
SPR_BASE, 25'h110000, first byte of sprite ROM
TILE_BASE, 25'h310000, first byte of tile ROM
SAMP_BASE, 25'h510000, first byte of sample ROM (extends to end of address space)

Ports:
clock  in  1  core clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
ioctl_download  in  1  download in progress
ioctl_wr  in  1  byte strobe, one cycle per byte
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
ioctl_index  in  8  download index
ioctl_wait  out  1  back-pressure to the download source
mem_req  out  1  word write request
mem_region  out  3  0=CPU 1=SND 2=SPR 3=TILE 4=SAMP
mem_addr  out  24  word offset within region: (byte addr - region base) >> 1
mem_data  out  16  low byte = even address, high byte = odd address
mem_be  out  2  byte enables {hi,lo}
mem_ack  in  1  write accepted this cycle
rom_ready  out  1  level: last download completed and drained
overflow  out  1  sticky: a byte was dropped

Behaviour:
- Reset values: ioctl_wait=0, mem_req=0, mem_region/addr/data/be=0, rom_ready=0, overflow=0. FIFO empty, pending-byte register invalid. Reset mid-download discards all buffered data.
- Accepted byte: ioctl_download & ioctl_wr & (ioctl_index==ROM_INDEX).
- Packing (at most one FIFO push per cycle):
  - Even-address byte with no pending byte: store it as pending (data, addr[24:1]). No push.
  - Even-address byte with a pending byte: push the old pending byte as be=01, then store the new byte as pending.
  - Odd-address byte whose addr[24:1] matches the pending byte: push a full word (be=11) and clear pending.
  - Odd-address byte with no pending byte or a mismatched address: push it alone (be=10, data[7:0]=0). Any mismatched pending byte is first pushed as be=01. This needs two pushes: the odd byte is held one cycle, and ioctl_wait is asserted for that cycle.
  - Falling edge of ioctl_download with a byte pending: push the pending byte as be=01.
- Region decode uses the word's byte address at push time: compare against SND/SPR/TILE/SAMP_BASE (>=), subtract the selected base, shift right 1.
- FIFO:
  - Push and pop in the same cycle are legal; count is unchanged.
  - ioctl_wait = (count >= FIFO_DEPTH-1) | two-push hold. Registered, so it reflects count after this edge.
  - A byte that would push into a full FIFO is dropped and sets overflow. overflow clears only on reset.
- Memory handshake:
  - mem_req=1 whenever the FIFO is non-empty. mem_* shows the head entry.
  - The head is held stable until a clock edge with mem_req & mem_ack, which pops it.
  - Back-to-back requests are allowed; first-word latency is 1 cycle after push.
  - mem_ack without mem_req is ignored.
- Completion:
  - rom_ready rises one cycle after all of these hold together: download low, no pending byte, FIFO empty, no held odd byte.
  - rom_ready clears on the rising edge of ioctl_download with a matching index.
  - A download for another index leaves rom_ready unchanged.
- Address wrap: a byte address at or beyond SAMP_BASE maps to region 4 with a 24-bit offset truncated modulo 2^24.

Decomposition:
- Package m72_loader_pkg holds:
  - region enum (REG_CPU..REG_SAMP);
  - the default base constants;
  - a struct {region, addr, data, be} used as the FIFO entry.
- Sub-module m72_loader_fifo: synchronous FIFO parameterised by depth and entry type, with count, full and empty outputs.

Test Plan:
- Sequential bytes 0x11 @0, 0x22 @1, mem_ack tied 1 -> one request: region 0, addr 0, data 0x2211, be 11; rom_ready=1 after download falls.
- Bytes at 0x110000/0x110001 = 0xAA/0xBB -> region 2, addr 0, data 0xBBAA; byte pair at 0x510004/5 -> region 4, addr 2.
- mem_ack held 0 while streaming 10 contiguous bytes one per cycle -> ioctl_wait rises once count reaches 3 words. Resuming ack drains all 5 words in order with no loss; overflow stays 0.
- Lone even byte 0x5A @0x20 then download falls -> one write: addr 0x10, data 0x005A, be 01.
- Bytes @4 then @7 (non-contiguous) -> two writes: addr 2, be 01; then addr 3, be 10. ioctl_wait pulses one cycle.
- Assert reset_n=0 mid-stream with 2 words queued -> mem_req drops asynchronously, no further writes; the next download starts cleanly with rom_ready=0.
